// File: rtl/multi_pump_controller.sv
// Multi-pump cistern controller: debounced level sensing, lead/lag pump rotation,
// minimum off-time, run-time watchdog and hysteretic inlet solenoid.
module multi_pump_controller #(
  parameter int LVL_W         = 3,
  parameter int LVL_MAX       = 4,
  parameter int START_SUP_MAX = 1,
  parameter int START_INF_MIN = 3,
  parameter int STOP_SUP_MIN  = 3,
  parameter int STOP_INF_MAX  = 1,
  parameter int ASSIST_LVL    = 0,
  parameter int SOL_REOPEN    = 3,
  parameter int DEBOUNCE_CYC  = 4,
  parameter int MIN_OFF_CYC   = 8,
  parameter int MAX_RUN_CYC   = 64,
  parameter int NUM_PUMPS     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LVL_W-1:0]     lvl_inf_raw,
  input  logic [LVL_W-1:0]     lvl_sup_raw,
  input  logic                 fault_clr,
  output logic [NUM_PUMPS-1:0] pump_on,
  output logic                 solenoid_open,
  output logic                 fault,
  output logic [2:0]           lead_idx,
  output logic [LVL_W-1:0]     lvl_inf,
  output logic [LVL_W-1:0]     lvl_sup,
  output logic [1:0]           state
);

  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int OFF_W = (MIN_OFF_CYC  > 1) ? $clog2(MIN_OFF_CYC)  : 1;
  localparam int RUN_W = $clog2(MAX_RUN_CYC);

  localparam logic [LVL_W-1:0] FULL_L      = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] START_SUP_L = LVL_W'(START_SUP_MAX);
  localparam logic [LVL_W-1:0] START_INF_L = LVL_W'(START_INF_MIN);
  localparam logic [LVL_W-1:0] STOP_SUP_L  = LVL_W'(STOP_SUP_MIN);
  localparam logic [LVL_W-1:0] STOP_INF_L  = LVL_W'(STOP_INF_MAX);
  localparam logic [LVL_W-1:0] ASSIST_L    = LVL_W'(ASSIST_LVL);
  localparam logic [LVL_W-1:0] REOPEN_L    = LVL_W'(SOL_REOPEN);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [OFF_W-1:0] OFF_LAST    = OFF_W'(MIN_OFF_CYC - 1);
  localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(MAX_RUN_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    COOLDOWN = 2'd2,
    FAULT    = 2'd3
  } state_t;

  // Saturate a raw sensor code to the full-scale value.
  function automatic logic [LVL_W-1:0] sat_lvl(input logic [LVL_W-1:0] raw);
    return (raw > FULL_L) ? FULL_L : raw;
  endfunction

  // Successor pump index, wrapping at NUM_PUMPS.
  function automatic logic [2:0] next_pump(input logic [2:0] idx);
    return (idx == 3'(NUM_PUMPS - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  logic [LVL_W-1:0] inf_sat_p0, sup_sat_p0;
  logic [LVL_W-1:0] inf_cand_p0, sup_cand_p0;
  logic [DB_W-1:0]  inf_cnt_p0, sup_cnt_p0;

  state_t                 state_q, state_nxt;
  logic [2:0]             lead_nxt;
  logic                   fault_nxt;
  logic [RUN_W-1:0]       run_cnt, run_nxt;
  logic [OFF_W-1:0]       off_cnt, off_nxt;
  logic [NUM_PUMPS-1:0]   pump_nxt;
  logic                   sol_nxt;
  logic                   start_ok, stop_ok, assist_on;

  assign inf_sat_p0 = sat_lvl(lvl_inf_raw);
  assign sup_sat_p0 = sat_lvl(lvl_sup_raw);

  // ---- stage p0 -> p1: debounce filters, one per level channel ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inf_cand_p0 <= '0;
      inf_cnt_p0  <= '0;
      lvl_inf     <= '0;
    end else if (inf_sat_p0 != inf_cand_p0) begin
      inf_cand_p0 <= inf_sat_p0;
      inf_cnt_p0  <= '0;
    end else if (inf_cnt_p0 == DB_LAST) begin
      lvl_inf <= inf_cand_p0;
    end else begin
      inf_cnt_p0 <= inf_cnt_p0 + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sup_cand_p0 <= '0;
      sup_cnt_p0  <= '0;
      lvl_sup     <= '0;
    end else if (sup_sat_p0 != sup_cand_p0) begin
      sup_cand_p0 <= sup_sat_p0;
      sup_cnt_p0  <= '0;
    end else if (sup_cnt_p0 == DB_LAST) begin
      lvl_sup <= sup_cand_p0;
    end else begin
      sup_cnt_p0 <= sup_cnt_p0 + 1'b1;
    end
  end

  // ---- stage p1 -> p2: control FSM on filtered levels ----
  assign start_ok  = (lvl_sup <= START_SUP_L) && (lvl_inf >= START_INF_L);
  assign stop_ok   = (lvl_sup >= STOP_SUP_L)  || (lvl_inf <= STOP_INF_L);
  assign assist_on = (NUM_PUMPS > 1) && (lvl_sup <= ASSIST_L);

  always_comb begin
    state_nxt = state_q;
    lead_nxt  = lead_idx;
    fault_nxt = fault;
    run_nxt   = '0;
    off_nxt   = '0;
    pump_nxt  = '0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_nxt = RUN;
      end
      RUN: begin
        // A normal stop wins over the watchdog when both fire together.
        if (stop_ok) begin
          state_nxt = COOLDOWN;
          lead_nxt  = next_pump(lead_idx);
        end else if (run_cnt == RUN_LAST) begin
          state_nxt = FAULT;
          fault_nxt = 1'b1;
        end else begin
          run_nxt = run_cnt + 1'b1;
        end
      end
      COOLDOWN: begin
        if (off_cnt == OFF_LAST) state_nxt = IDLE;
        else                     off_nxt   = off_cnt + 1'b1;
      end
      FAULT: begin
        fault_nxt = 1'b1;
        if (fault_clr) begin
          state_nxt = COOLDOWN;
          fault_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == RUN) begin
      for (int i = 0; i < NUM_PUMPS; i++) begin
        if (3'(i) == lead_nxt) pump_nxt[i] = 1'b1;
        if (assist_on && (3'(i) == next_pump(lead_nxt))) pump_nxt[i] = 1'b1;
      end
    end
  end

  // Valve hysteresis: close at full scale, reopen only once back at or below the reopen mark.
  always_comb begin
    sol_nxt = solenoid_open;
    if (lvl_inf == FULL_L)         sol_nxt = 1'b0;
    else if (lvl_inf <= REOPEN_L)  sol_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lead_idx      <= 3'd0;
      fault         <= 1'b0;
      run_cnt       <= '0;
      off_cnt       <= '0;
      pump_on       <= '0;
      solenoid_open <= 1'b1;
    end else begin
      state_q       <= state_nxt;
      lead_idx      <= lead_nxt;
      fault         <= fault_nxt;
      run_cnt       <= run_nxt;
      off_cnt       <= off_nxt;
      pump_on       <= pump_nxt;
      solenoid_open <= sol_nxt;
    end
  end

  assign state = state_q;

endmodule
